// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_sequencer
// Brief    : Round-robin scan controller for a shared 8-bit ADC. Converts each
//            sample to three BCD digits, tagged with the channel number.
// Revision : 1.0  initial release
// ============================================================================
module adc_scan_sequencer #(
  parameter  int NCH     = 4,
  parameter  int START_W = 10,
  parameter  int TIMEOUT = 100,
  parameter  int PERIOD  = 50000,
  localparam int CH_W    = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            eoc,
  input  logic [7:0]      D,
  output logic            start,
  output logic [CH_W-1:0] ch_sel,
  output logic            busy,
  output logic [3:0]      bcd_tr,
  output logic [3:0]      bcd_ch,
  output logic [3:0]      bcd_dv,
  output logic [CH_W-1:0] res_ch,
  output logic            res_valid,
  output logic            timeout_err
);

  localparam int c_CNT_MAX = (START_W > TIMEOUT) ? ((START_W > 8) ? START_W : 8)
                                                 : ((TIMEOUT > 8) ? TIMEOUT : 8);
  localparam int c_CNT_W   = $clog2(c_CNT_MAX);
  localparam int c_PER_W   = $clog2(PERIOD);

  localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_W - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CONV_LAST  = c_CNT_W'(7);
  localparam logic [c_PER_W-1:0] c_PER_LAST   = c_PER_W'(PERIOD - 1);
  localparam logic [CH_W-1:0]    c_CH_LAST    = CH_W'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_EOC = 3'd2,
    S_CAPTURE  = 3'd3,
    S_CONVERT  = 3'd4,
    S_DONE     = 3'd5,
    S_GAP      = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_eoc_hit;
  logic                 w_timeout;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_PER_W-1:0]   r_per_cnt;
  logic [7:0]           r_d_lat;
  logic [11:0]          r_bcd;
  logic [11:0]          w_bcd_adj;
  logic [19:0]          w_dd_next;

  logic                 r_start;
  logic                 r_busy;
  logic [CH_W-1:0]      r_ch_sel;
  logic [3:0]           r_bcd_tr;
  logic [3:0]           r_bcd_ch;
  logic [3:0]           r_bcd_dv;
  logic [CH_W-1:0]      r_res_ch;
  logic                 r_res_valid;
  logic                 r_timeout_err;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_eoc_hit    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) w_next_state = S_START;
      end
      S_START: begin
        if (r_cnt == c_START_LAST) w_next_state = S_WAIT_EOC;
      end
      S_WAIT_EOC: begin
        // eoc on the final wait cycle still wins over the timeout
        if (eoc) begin
          w_next_state = S_CAPTURE;
          w_eoc_hit    = 1'b1;
        end else if (r_cnt == c_TO_LAST) begin
          w_next_state = S_GAP;
          w_timeout    = 1'b1;
        end
      end
      S_CAPTURE: w_next_state = S_CONVERT;
      S_CONVERT: begin
        if (r_cnt == c_CONV_LAST) w_next_state = S_DONE;
      end
      S_DONE:    w_next_state = S_GAP;
      S_GAP: begin
        if (r_per_cnt == c_PER_LAST) w_next_state = en ? S_START : S_IDLE;
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters: r_cnt restarts on every state change, r_per_cnt on START entry
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_per_cnt <= '0;
    end else begin
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (r_state == S_START || r_state == S_WAIT_EOC || r_state == S_CONVERT) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      if (w_next_state == S_START && r_state != S_START) begin
        r_per_cnt <= '0;
      end else if (r_state != S_IDLE && r_per_cnt != c_PER_LAST) begin
        r_per_cnt <= r_per_cnt + c_PER_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Double-dabble datapath: add-3 correction then a 20-bit left shift
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_add3
    assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                              : r_bcd[gi*4 +: 4];
  end

  assign w_dd_next = {w_bcd_adj, r_d_lat} << 1;

  // D is latched on the edge eoc is accepted, while it is guaranteed valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_lat <= '0;
      r_bcd   <= '0;
    end else begin
      if (w_eoc_hit) begin
        r_d_lat <= D;
      end else if (r_state == S_CONVERT) begin
        r_d_lat <= w_dd_next[7:0];
      end

      if (r_state == S_CAPTURE) begin
        r_bcd <= '0;
      end else if (r_state == S_CONVERT) begin
        r_bcd <= w_dd_next[19:8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start       <= 1'b0;
      r_busy        <= 1'b0;
      r_ch_sel      <= '0;
      r_bcd_tr      <= '0;
      r_bcd_ch      <= '0;
      r_bcd_dv      <= '0;
      r_res_ch      <= '0;
      r_res_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_start       <= (w_next_state == S_START);
      r_busy        <= (w_next_state != S_IDLE);
      r_timeout_err <= w_timeout;
      r_res_valid   <= (r_state == S_CONVERT) && (w_next_state == S_DONE);

      // Final shift result lands on the outputs as the FSM enters DONE
      if (r_state == S_CONVERT && w_next_state == S_DONE) begin
        r_bcd_tr <= w_dd_next[19:16];
        r_bcd_ch <= w_dd_next[15:12];
        r_bcd_dv <= w_dd_next[11:8];
        r_res_ch <= r_ch_sel;
      end

      if (r_state == S_DONE || w_timeout) begin
        r_ch_sel <= (r_ch_sel == c_CH_LAST) ? '0 : (r_ch_sel + CH_W'(1));
      end
    end
  end

  assign start       = r_start;
  assign busy        = r_busy;
  assign ch_sel      = r_ch_sel;
  assign bcd_tr      = r_bcd_tr;
  assign bcd_ch      = r_bcd_ch;
  assign bcd_dv      = r_bcd_dv;
  assign res_ch      = r_res_ch;
  assign res_valid   = r_res_valid;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
